accel_seq_ctrl: RTL and testbench
=================================

Name: accel_seq_ctrl

Overview:
Job sequencer for the bit-reversal accelerator wrapper (FIFO-style din/write/start/done/read/dout interface). It accepts a job command carrying a word count and streams that many input words into the wrapper. It then pulses start, waits for done with a timeout, and drains the same number of results out as a valid/ready stream with a last flag. It sits between the host-side register/stream logic and the accelerator wrapper, and is the only master of the wrapper's control pins.

Parameters:
DATA_W, 32, data word width (matches wrapper din/dout)
MAX_LEN, 64, maximum words per job
LEN_W, 7, width of the length field (must hold MAX_LEN)
TIMEOUT, 1024, cycles allowed in WAIT before abort

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid_i  in  1  job command valid
cmd_ready_o  out  1  high only in IDLE
cmd_len_i  in  LEN_W  words in job
in_valid_i  in  1  input word valid
in_ready_o  out  1  high in LOAD
in_data_i  in  DATA_W  input word
out_valid_o  out  1  result word valid
out_ready_i  in  1  result consumer ready
out_data_o  out  DATA_W  result word
out_last_o  out  1  marks final result of job
busy_o  out  1  state != IDLE
err_timeout_o  out  1  sticky timeout flag; cleared when the next command is accepted
acc_din_o  out  DATA_W  to wrapper din_i
acc_write_o  out  1  to wrapper write_i
acc_start_o  out  1  to wrapper start_flag_i
acc_done_i  in  1  from wrapper done_flag_o
acc_read_o  out  1  to wrapper read_i
acc_dout_i  in  DATA_W  from wrapper dout_o, valid 1 cycle after acc_read_o

Behaviour:
- Reset (rst_n=0 at clock edge): state=IDLE, all counters 0, every output 0 except cmd_ready_o=1. A reset mid-job abandons the job and emits no further acc_* activity.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: latch len = min(cmd_len_i, MAX_LEN) and clear err_timeout_o.
  - len==0: no-op, stay in IDLE, no acc_* activity.
  - Otherwise go to LOAD.
- LOAD:
  - in_ready_o=1.
  - Each cycle with in_valid_i: acc_write_o=1 and acc_din_o=in_data_i, combinational pass-through in the same cycle; wr_cnt++.
  - When the len-th word is written, go to START.
  - acc_done_i is ignored.
- START: acc_start_o=1 for exactly one cycle, wait counter cleared, then go to WAIT.
- WAIT:
  - On acc_done_i=1: go to RD.
  - Otherwise wait counter++.
  - When the counter reaches TIMEOUT-1 without done: set err_timeout_o, return to IDLE, emit no output.
  - If done and timeout occur in the same cycle, done wins.
- RD: acc_read_o=1 for one cycle, then go to CAP.
- CAP: capture acc_dout_i into out_data_o, set out_valid_o=1, out_last_o=(rd_cnt==len-1), then go to OUT.
- OUT:
  - Hold out_data_o, out_valid_o and out_last_o stable until out_ready_i.
  - On the handshake cycle: out_valid_o falls next cycle, rd_cnt++.
  - If that word was last, go to IDLE; else go to RD.
  - Drain throughput is 1 word per 3 cycles minimum.
- Ready/valid rules:
  - Never more than one acc_read_o outstanding.
  - acc_write_o, acc_start_o and acc_read_o are mutually exclusive.
  - out_valid_o never drops without a handshake (except on reset).
- Latency, len=1, in_valid_i always high, done returned 2 cycles after start:
  - cmd accept cycle 0, write cycle 1, start cycle 2, done cycle 4.
  - Read cycle 5, out_valid_o high from cycle 7.
- busy_o=1 in all states except IDLE. A new command is not accepted until the current job returns to IDLE.

Test Plan:
- Reset then cmd_len_i=4 with inputs 0x00000001,0x00000002,0x80000000,0xFFFF0000, model returns the bit-reversed words -> out words 0x80000000,0x40000000,0x00000001,0x0000FFFF; out_last_o only on the 4th; exactly 4 write, 1 start and 4 read pulses.
- cmd_len_i=0 -> cmd_ready_o stays 1, busy_o stays 0, zero acc_* pulses.
- cmd_len_i=100 with MAX_LEN=64 -> exactly 64 writes and 64 results, last on word 64.
- Model never asserts done with TIMEOUT=16 -> err_timeout_o=1 exactly 16 cycles after the start pulse, back in IDLE, no out_valid_o. The next accepted command clears err_timeout_o.
- out_ready_i held low 10 cycles on word 2 -> out_data_o stable and no acc_read_o issued during the stall; order preserved.
- rst_n low during WAIT of a len=8 job -> next cycle all outputs at reset values; a following len=2 job completes normally.

Source files
------------

// File: rtl/accel_seq_ctrl_if.sv
// Handshake bundle between host logic, accel_seq_ctrl and the bit-reversal wrapper.
// master: sequencer side (drives cmd_ready/in_ready/out_*/acc_* controls).
// slave:  host + wrapper side (drives commands, input words, out_ready, done/dout).
interface accel_seq_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 7
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [LEN_W-1:0]  cmd_len_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
    logic              out_last_o;
    logic              busy_o;
    logic              err_timeout_o;
    logic [DATA_W-1:0] acc_din_o;
    logic              acc_write_o;
    logic              acc_start_o;
    logic              acc_done_i;
    logic              acc_read_o;
    logic [DATA_W-1:0] acc_dout_i;

    modport master (
        input  cmd_valid_i, cmd_len_i,
        input  in_valid_i, in_data_i,
        input  out_ready_i,
        input  acc_done_i, acc_dout_i,
        output cmd_ready_o, in_ready_o,
        output out_valid_o, out_data_o, out_last_o,
        output busy_o, err_timeout_o,
        output acc_din_o, acc_write_o,
        output acc_start_o, acc_read_o
    );

    modport slave (
        output cmd_valid_i, cmd_len_i,
        output in_valid_i, in_data_i,
        output out_ready_i,
        output acc_done_i, acc_dout_i,
        input  cmd_ready_o, in_ready_o,
        input  out_valid_o, out_data_o, out_last_o,
        input  busy_o, err_timeout_o,
        input  acc_din_o, acc_write_o,
        input  acc_start_o, acc_read_o
    );
endinterface

// File: rtl/accel_seq_ctrl.sv
// Job sequencer for the bit-reversal wrapper: load N words, start, wait done, drain N results.
// Ports: clk, rst_n (sync, active low), bus (accel_seq_ctrl_if.master: cmd/in/out streams + acc_* pins).
module accel_seq_ctrl #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7,
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    accel_seq_ctrl_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WAIT, RD, CAP, OUT
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  wr_cnt;
    logic [LEN_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              cmd_ready;
    logic              busy;
    logic              in_ready;
    logic              start;
    logic              read;
    logic              out_valid;
    logic              out_last;
    logic              err;
    logic [DATA_W-1:0] out_data;
    logic [LEN_W-1:0]  len_clamp;
    logic              wr_fire;

    assign len_clamp = (bus.cmd_len_i > LEN_W'(MAX_LEN))
                     ? LEN_W'(MAX_LEN) : bus.cmd_len_i;
    assign wr_fire   = in_ready & bus.in_valid_i;

    // Write strobe and data pass straight through while loading.
    assign bus.acc_write_o   = wr_fire;
    assign bus.acc_din_o     = wr_fire ? bus.in_data_i : '0;
    assign bus.acc_start_o   = start;
    assign bus.acc_read_o    = read;
    assign bus.cmd_ready_o   = cmd_ready;
    assign bus.in_ready_o    = in_ready;
    assign bus.busy_o        = busy;
    assign bus.err_timeout_o = err;
    assign bus.out_valid_o   = out_valid;
    assign bus.out_data_o    = out_data;
    assign bus.out_last_o    = out_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            len       <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            wait_cnt  <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            start     <= 1'b0;
            read      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid_i) begin
                        len <= len_clamp;
                        err <= 1'b0;
                        if (len_clamp != '0) begin
                            state     <= LOAD;
                            wr_cnt    <= '0;
                            rd_cnt    <= '0;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                            in_ready  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (wr_fire) begin
                        wr_cnt <= wr_cnt + LEN_W'(1);
                        if (wr_cnt == len - LEN_W'(1)) begin
                            state    <= START;
                            in_ready <= 1'b0;
                            start    <= 1'b1;
                        end
                    end
                end
                START: begin
                    start    <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (bus.acc_done_i) begin
                        state <= RD;
                        read  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        // Abort as the counter steps onto TIMEOUT-1.
                        if (wait_cnt == CNT_W'(TIMEOUT - 2)) begin
                            err       <= 1'b1;
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                RD: begin
                    read  <= 1'b0;
                    state <= CAP;
                end
                CAP: begin
                    // Wrapper dout is valid the cycle after the read strobe.
                    out_data  <= bus.acc_dout_i;
                    out_valid <= 1'b1;
                    out_last  <= (rd_cnt == len - LEN_W'(1));
                    state     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready_i) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        rd_cnt    <= rd_cnt + LEN_W'(1);
                        if (out_last) begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state <= RD;
                            read  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    start     <= 1'b0;
                    read      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Self-checking bench for accel_seq_ctrl with a behavioural bit-reversal wrapper.
// Table of job vectors plus hand sequences for reset-in-WAIT recovery.
module tb_accel_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accel_seq_ctrl_if #(.DATA_W(32), .LEN_W(7)) bus ();

    accel_seq_ctrl #(
        .DATA_W(32), .MAX_LEN(64), .LEN_W(7), .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_wr = 0;
    int n_st = 0;
    int n_rd = 0;
    int mon_bad = 0;

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // Behavioural wrapper: stores writes, done 2 cycles after start, dout 1 cycle after read.
    logic [31:0] mem [0:127];
    int mw = 0;
    int mr = 0;
    int dcnt = 0;
    bit done_en = 1'b1;

    assign bus.acc_done_i = (dcnt == 1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            mw <= 0;
            mr <= 0;
            dcnt <= 0;
            bus.acc_dout_i <= '0;
        end else begin
            if (bus.cmd_valid_i && bus.cmd_ready_o) mw <= 0;
            if (bus.acc_write_o) begin
                mem[mw] <= bus.acc_din_o;
                mw <= mw + 1;
            end
            if (bus.acc_start_o) begin
                dcnt <= done_en ? 2 : 0;
                mr <= 0;
            end else if (dcnt > 0) begin
                dcnt <= dcnt - 1;
            end
            if (bus.acc_read_o) begin
                bus.acc_dout_i <= rev32(mem[mr]);
                mr <= mr + 1;
            end
            if (bus.acc_write_o) n_wr <= n_wr + 1;
            if (bus.acc_start_o) n_st <= n_st + 1;
            if (bus.acc_read_o) n_rd <= n_rd + 1;
            if ($countones({bus.acc_write_o, bus.acc_start_o,
                            bus.acc_read_o}) > 1)
                mon_bad <= mon_bad + 1;
        end
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     name, act, exp);
        end
    endtask

    typedef struct {
        logic [6:0] len;
        bit done_en;
        int stall_word;
        int exp_wr;
        int exp_rd;
        bit exp_err;
        bit exp_busy;
        bit chk_lat;
        bit use_lit;
    } vec_t;

    vec_t vecs [7];
    logic [31:0] src [0:127];
    logic [31:0] exp0 [0:3];

    task automatic fill_src(input bit use_lit);
        for (int i = 0; i < 128; i++)
            src[i] = (i + 1) * 32'h0103_0507 ^ 32'h0F00_00F0;
        if (use_lit) begin
            src[0] = 32'h0000_0001;
            src[1] = 32'h0000_0002;
            src[2] = 32'h8000_0000;
            src[3] = 32'hFFFF_0000;
        end
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int wb, sb, rb, widx, ridx, t, t0;
        int stall_cnt, stall_bad, last_bad, idle_bad;
        int t_wr, t_st, t_rd, t_val, t_err;
        bit busy_seen, seen_valid;
        logic [31:0] held, exp;
        wb = n_wr; sb = n_st; rb = n_rd;
        widx = 0; ridx = 0; t = 0;
        stall_cnt = 0; stall_bad = 0;
        last_bad = 0; idle_bad = 0;
        t_wr = -1; t_st = -1; t_rd = -1;
        t_val = -1; t_err = -1;
        busy_seen = 0; seen_valid = 0;
        held = '0;
        fill_src(v.use_lit);
        done_en = v.done_en;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_len_i = v.len;
        bus.in_valid_i = 1'b1;
        bus.in_data_i = src[0];
        bus.out_ready_i = 1'b1;
        #1;
        check({tag, " cmd_ready"}, 32'(bus.cmd_ready_o), 32'd1);
        t0 = cyc;
        forever begin
            @(negedge clk);
            bus.cmd_valid_i = 1'b0;
            bus.in_data_i = src[widx % 128];
            if (bus.out_valid_o && ridx == v.stall_word
                && stall_cnt < 10) begin
                bus.out_ready_i = 1'b0;
                stall_cnt++;
            end else begin
                bus.out_ready_i = 1'b1;
            end
            #1;
            t = cyc - t0;
            if (bus.busy_o) busy_seen = 1;
            if (!v.exp_busy && !bus.cmd_ready_o) idle_bad++;
            if (bus.acc_write_o) begin
                if (t_wr < 0) t_wr = t;
                widx++;
            end
            if (bus.acc_start_o && t_st < 0) t_st = t;
            if (bus.acc_read_o && t_rd < 0) t_rd = t;
            if (bus.err_timeout_o && t_err < 0) t_err = t;
            if (bus.out_valid_o) begin
                seen_valid = 1;
                if (t_val < 0) t_val = t;
            end
            if (bus.out_valid_o && !bus.out_ready_i) begin
                if (stall_cnt == 1) held = bus.out_data_o;
                else if (bus.out_data_o !== held) stall_bad++;
                if (bus.acc_read_o) stall_bad++;
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                exp = v.use_lit ? exp0[ridx % 4]
                                : rev32(src[ridx % 128]);
                check($sformatf("%s data[%0d]", tag, ridx),
                      bus.out_data_o, exp);
                if (bus.out_last_o != (ridx == v.exp_rd - 1))
                    last_bad++;
                ridx++;
            end
            if (bus.cmd_ready_o && (busy_seen || t >= 4)) break;
            if (t > 3000) begin
                check({tag, " job_timeout"}, 32'(t), 32'd3000);
                break;
            end
        end
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        check({tag, " writes"}, 32'(n_wr - wb), 32'(v.exp_wr));
        check({tag, " starts"}, 32'(n_st - sb), 32'(v.exp_busy));
        check({tag, " reads"}, 32'(n_rd - rb), 32'(v.exp_rd));
        check({tag, " results"}, 32'(ridx), 32'(v.exp_rd));
        check({tag, " last_flag"}, 32'(last_bad), 32'd0);
        check({tag, " err"}, 32'(bus.err_timeout_o), 32'(v.exp_err));
        check({tag, " busy_seen"}, 32'(busy_seen), 32'(v.exp_busy));
        check({tag, " idle_ready"}, 32'(idle_bad), 32'd0);
        if (v.stall_word >= 0) begin
            check({tag, " stall_len"}, 32'(stall_cnt), 32'd10);
            check({tag, " stall_hold"}, 32'(stall_bad), 32'd0);
        end
        if (v.exp_err) begin
            check({tag, " err_delay"}, 32'(t_err - t_st), 32'd16);
            check({tag, " no_valid"}, 32'(seen_valid), 32'd0);
            check({tag, " busy_end"}, 32'(bus.busy_o), 32'd0);
        end
        if (v.chk_lat) begin
            check({tag, " lat_wr"}, 32'(t_wr), 32'd1);
            check({tag, " lat_start"}, 32'(t_st), 32'd2);
            check({tag, " lat_read"}, 32'(t_rd), 32'd5);
            check({tag, " lat_valid"}, 32'(t_val), 32'd7);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " cmd_ready"}, 32'(bus.cmd_ready_o), 32'd1);
        check({tag, " busy"}, 32'(bus.busy_o), 32'd0);
        check({tag, " in_ready"}, 32'(bus.in_ready_o), 32'd0);
        check({tag, " out_valid"}, 32'(bus.out_valid_o), 32'd0);
        check({tag, " out_last"}, 32'(bus.out_last_o), 32'd0);
        check({tag, " out_data"}, bus.out_data_o, 32'd0);
        check({tag, " err"}, 32'(bus.err_timeout_o), 32'd0);
        check({tag, " acc_ctl"},
              {29'd0, bus.acc_write_o, bus.acc_start_o,
               bus.acc_read_o}, 32'd0);
        check({tag, " acc_din"}, bus.acc_din_o, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, sb, rb, w;
        vec_t hv;
        exp0[0] = 32'h8000_0000;
        exp0[1] = 32'h4000_0000;
        exp0[2] = 32'h0000_0001;
        exp0[3] = 32'h0000_FFFF;
        //          len  done stall wr  rd  err busy lat lit
        vecs[0] = '{7'd4,   1, -1,  4,  4, 0, 1, 0, 1};
        vecs[1] = '{7'd0,   1, -1,  0,  0, 0, 0, 0, 0};
        vecs[2] = '{7'd100, 1, -1, 64, 64, 0, 1, 0, 0};
        vecs[3] = '{7'd5,   1,  1,  5,  5, 0, 1, 0, 0};
        vecs[4] = '{7'd3,   0, -1,  3,  0, 1, 1, 0, 0};
        vecs[5] = '{7'd0,   1, -1,  0,  0, 0, 0, 0, 0};
        vecs[6] = '{7'd1,   1, -1,  1,  1, 0, 1, 1, 0};

        bus.cmd_valid_i = 1'b0;
        bus.cmd_len_i = '0;
        bus.in_valid_i = 1'b0;
        bus.in_data_i = '0;
        bus.out_ready_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_job(vecs[i], $sformatf("vec%0d", i));

        // Reset while a len=8 job sits in WAIT.
        fill_src(0);
        done_en = 1'b0;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_len_i = 7'd8;
        bus.in_valid_i = 1'b1;
        bus.in_data_i = src[0];
        w = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            bus.cmd_valid_i = 1'b0;
            bus.in_data_i = src[w];
            #1;
            if (bus.acc_write_o) w++;
            if (bus.acc_start_o) break;
        end
        bus.in_valid_i = 1'b0;
        check("rstw writes", 32'(w), 32'd8);
        repeat (3) @(negedge clk);
        #1;
        check("rstw in_wait", 32'(bus.busy_o), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset_vals("rstw");
        rst_n = 1'b1;
        wb = n_wr; sb = n_st; rb = n_rd;
        repeat (20) @(negedge clk);
        #1;
        check("rstw quiet",
              32'((n_wr - wb) + (n_st - sb) + (n_rd - rb)), 32'd0);
        check("rstw idle", 32'(bus.cmd_ready_o), 32'd1);

        hv = '{7'd2, 1, -1, 2, 2, 0, 1, 0, 0};
        run_job(hv, "after_rst");

        check("acc_exclusive", 32'(mon_bad), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
